max7219_chain_serializer: RTL

- Parametrised frame serializer for a cascade of MAX7219-style shift-register devices.
- Accepts a DEV×W-bit frame on a start strobe, shifts it out on sck/mosi at a programmable rate, then pulses cs_n high to latch all devices.
- Reports per-word progress and frame completion with a start/busy/done handshake.
- Sits between the display-refresh FSM and the board pins.

---
 rtl/max7219_chain_serializer_if.sv | 25 ++
 rtl/max7219_chain_serializer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/max7219_chain_serializer_if.sv
// Frame request / status / pin bundle between the refresh FSM
// and the MAX7219 chain serializer.
interface max7219_chain_serializer_if #(
    parameter int W   = 16,
    parameter int DEV = 4
);
    logic             start;
    logic [W*DEV-1:0] din;
    logic             busy;
    logic             done;
    logic             word_tick;
    logic             sck;
    logic             mosi;
    logic             cs_n;

    modport master (
        output start, din,
        input  busy, done, word_tick, sck, mosi, cs_n
    );

    modport slave (
        input  start, din,
        output busy, done, word_tick, sck, mosi, cs_n
    );
endinterface

// File: rtl/max7219_chain_serializer.sv
// Serializes a DEV*W-bit frame onto sck/mosi for a MAX7219
// daisy chain, then raises cs_n to latch every device at once.
module max7219_chain_serializer #(
    parameter int W         = 16,
    parameter int DEV       = 4,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic reset,
    max7219_chain_serializer_if.slave bus
);
    localparam int N   = W * DEV;
    localparam int BCW = $clog2(N);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WCW = $clog2(W);

    localparam logic [BCW-1:0] BC_LAST = BCW'(N - 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(DIV - 1);
    localparam logic [DCW-1:0] DC_PRE  = DCW'((DIV > 1) ? DIV - 2 : 0);
    localparam logic [WCW-1:0] WC_LAST = WCW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_LATCH,
        S_GAP
    } state_e;

    state_e         state_q;
    logic [N-1:0]   sr_q;
    logic [N-1:0]   sr_d;
    logic [BCW-1:0] bc_q;
    logic [DCW-1:0] dc_q;
    logic [WCW-1:0] wc_q;
    logic           busy_q;
    logic           done_q;
    logic           word_tick_q;
    logic           sck_q;
    logic           mosi_q;
    logic           cs_n_q;

    function automatic logic out_bit(input logic [N-1:0] v);
        return MSB_FIRST ? v[N-1] : v[0];
    endfunction

    always_comb begin
        sr_d = MSB_FIRST ? {sr_q[N-2:0], 1'b0} : {1'b0, sr_q[N-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            bc_q        <= '0;
            dc_q        <= '0;
            wc_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            word_tick_q <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            done_q      <= 1'b0;
            word_tick_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        sr_q    <= bus.din;
                        mosi_q  <= out_bit(bus.din);
                        bc_q    <= BC_LAST;
                        wc_q    <= WC_LAST;
                        dc_q    <= '0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (dc_q == DC_LAST) begin
                        dc_q    <= '0;
                        sck_q   <= 1'b1;
                        state_q <= S_HIGH;
                        // With DIV=1 the first HIGH cycle is also the last
                        word_tick_q <= (DIV == 1) && (wc_q == '0);
                    end else begin
                        dc_q <= dc_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (dc_q == DC_LAST) begin
                        dc_q  <= '0;
                        sck_q <= 1'b0;
                        wc_q  <= (wc_q == '0) ? WC_LAST : wc_q - 1'b1;
                        if (bc_q == '0) begin
                            state_q <= S_LATCH;
                        end else begin
                            sr_q    <= sr_d;
                            mosi_q  <= out_bit(sr_d);
                            bc_q    <= bc_q - 1'b1;
                            state_q <= S_LOW;
                        end
                    end else begin
                        dc_q        <= dc_q + 1'b1;
                        word_tick_q <= (dc_q == DC_PRE) && (wc_q == '0);
                    end
                end
                S_LATCH: begin
                    if (dc_q == DC_LAST) begin
                        dc_q    <= '0;
                        cs_n_q  <= 1'b1;
                        state_q <= S_GAP;
                    end else begin
                        dc_q <= dc_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (dc_q == DC_LAST) begin
                        dc_q    <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        dc_q <= dc_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.word_tick = word_tick_q;
    assign bus.sck       = sck_q;
    assign bus.mosi      = mosi_q;
    assign bus.cs_n      = cs_n_q;
endmodule
